// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the requesters/resource and the round-robin arbiter.
`timescale 1ns/1ps
interface bus_arbiter_if #(
   parameter int NR_REQ  = 4,
   parameter int KEY_LEN = 2
);
   logic [NR_REQ-1:0]  req;
   logic               done;
   logic [NR_REQ-1:0]  gnt;
   logic [KEY_LEN-1:0] sel_key;
   logic               busy;
   logic               timeout_err;

   modport master (
      output req, done,
      input  gnt, sel_key, busy, timeout_err
   );

   modport slave (
      input  req, done,
      output gnt, sel_key, busy, timeout_err
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one shared resource, with a forced release if done never arrives.
//   state | meaning
//   IDLE  | no grant held; arbitrate on any nonzero req
//   BUSY  | grant held until done or wait counter expiry
`timescale 1ns/1ps
module bus_arbiter #(
   parameter int NR_REQ  = 4,
   parameter int KEY_LEN = 2,
   parameter int TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst_n,
   bus_arbiter_if.slave arb
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [15:0]        CNT_LAST = 16'(TIMEOUT - 1);
   localparam logic [KEY_LEN-1:0] KEY_MAX  = KEY_LEN'(NR_REQ - 1);

   state_t             state_q, state_d;
   logic [NR_REQ-1:0]  gnt_q, gnt_d;
   logic [KEY_LEN-1:0] key_q, key_d;
   logic [KEY_LEN-1:0] ptr_q, ptr_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               terr_q, terr_d;
   logic               win_found;
   logic [KEY_LEN-1:0] win_idx;

   // Scan downward so the last hit written is the nearest one at or after ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NR_REQ - 1; k >= 0; k--) begin
         if (arb.req[(int'(ptr_q) + k) % NR_REQ]) begin
            win_found = 1'b1;
            win_idx   = KEY_LEN'((int'(ptr_q) + k) % NR_REQ);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      key_d   = key_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               gnt_d   = NR_REQ'(1) << win_idx;
               key_d   = win_idx;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (arb.done || (cnt_q == CNT_LAST)) begin
               gnt_d   = '0;
               ptr_d   = (key_q == KEY_MAX) ? '0 : key_q + KEY_LEN'(1);
               terr_d  = !arb.done;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         key_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         key_q   <= key_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   assign arb.gnt         = gnt_q;
   assign arb.sel_key     = key_q;
   assign arb.busy        = (state_q == BUSY);
   assign arb.timeout_err = terr_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed checks of bus_arbiter (NR_REQ=4, TIMEOUT=8): vector table plus timeout/reset sequences.
`timescale 1ns/1ps
module tb_bus_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bus_arbiter_if #(.NR_REQ(4), .KEY_LEN(2)) bus ();

   bus_arbiter #(.NR_REQ(4), .KEY_LEN(2), .TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (bus.slave)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] gnt;
      logic [1:0] key;
      logic       busy;
      logic       terr;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic add(input logic r, input logic [3:0] rq, input logic d,
                      input logic [3:0] g, input logic [1:0] k, input logic b, input logic t);
      vec_t v;
      v.rst = r; v.req = rq; v.done = d; v.gnt = g; v.key = k; v.busy = b; v.terr = t;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [3:0] g, input logic [1:0] k,
                        input logic b, input logic t);
      logic [7:0] act, exp;
      act = {bus.gnt, bus.sel_key, bus.busy, bus.timeout_err};
      exp = {g, k, b, t};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: {gnt,key,busy,terr} got %b_%0d_%b_%b expected %b_%0d_%b_%b",
                  nm, act[7:4], act[3:2], act[1], act[0], g, k, b, t);
      end
   endtask

   task automatic do_reset();
      bus.req  = '0;
      bus.done = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req  = '0;
      bus.done = 1'b0;

      // reset, then full rotation with done two cycles after each grant
      add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
      add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
      add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 2, 0, 0);
      add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
      add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 3, 0, 0);
      add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
      // single request, then wrap-and-skip from ptr=3
      add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
      add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 2, 0, 0);
      add(0, 4'b0101, 0, 4'b0001, 0, 1, 0);
      add(0, 4'b0101, 1, 4'b0000, 0, 0, 0);
      add(0, 4'b0101, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b0101, 1, 4'b0000, 2, 0, 0);
      // hold while busy, ignore done in idle (ptr=3 here)
      add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
      add(0, 4'b1101, 0, 4'b0010, 1, 1, 0);
      add(0, 4'b1101, 0, 4'b0010, 1, 1, 0);
      add(0, 4'b1101, 1, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 1, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 2, 0, 0);

      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            do_reset();
         end else begin
            bus.req  = vecs[i].req;
            bus.done = vecs[i].done;
            step();
         end
         check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].key, vecs[i].busy, vecs[i].terr);
      end

      // timeout: grant to requester 1, done never arrives
      do_reset();
      bus.req = 4'b0010;
      step();
      check("to_grant", 4'b0010, 1, 1, 0);
      bus.req = 4'b0000;
      for (int c = 2; c <= 8; c++) begin
         step();
         check($sformatf("to_hold%0d", c), 4'b0010, 1, 1, 0);
      end
      step();
      check("to_release", 4'b0000, 1, 0, 1);
      step();
      check("to_pulse_end", 4'b0000, 1, 0, 0);
      bus.req = 4'b1111;
      step();
      check("to_ptr2", 4'b0100, 2, 1, 0);
      bus.req  = 4'b0000;
      bus.done = 1'b1;
      step();
      check("to_done", 4'b0000, 2, 0, 0);
      bus.done = 1'b0;

      // done coinciding with the last wait cycle wins over the timeout
      do_reset();
      bus.req = 4'b0010;
      step();
      bus.req = 4'b0000;
      for (int c = 2; c <= 8; c++) step();
      bus.done = 1'b1;
      step();
      check("coinc_release", 4'b0000, 1, 0, 0);
      bus.done = 1'b0;
      step();
      check("coinc_no_err", 4'b0000, 1, 0, 0);

      // asynchronous reset mid-grant
      do_reset();
      bus.req = 4'b1000;
      step();
      check("ar_grant", 4'b1000, 3, 1, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_async", 4'b0000, 0, 0, 0);
      bus.req = 4'b1010;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("ar_regrant", 4'b0010, 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NR_REQ, default 4, meaning number of requesters sharing the resource (2..16).
REQ-002 Parameter KEY_LEN, default 2, meaning width of the binary select key (ceil(log2(NR_REQ))).
REQ-003 Parameter TIMEOUT, default 255, meaning max cycles a grant may wait for done before forced release (1..65535).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  NR_REQ  per-requester request level; bit i = requester i.
REQ-007 done  input  1  resource signals completion of the current granted transfer (single-cycle pulse).
REQ-008 gnt  output  NR_REQ  one-hot grant, registered; all-zero when idle.
REQ-009 sel_key  output  KEY_LEN  binary index of granted requester, drives the key of the shared-path mux selector.
REQ-010 busy  output  1  high while a grant is held.
REQ-011 timeout_err  output  1  single-cycle pulse on forced release.

Function
REQ-012 The block SHALL implement two states: IDLE and BUSY.
REQ-013 The block SHALL keep a round-robin pointer ptr (KEY_LEN bits) naming the highest-priority requester.
REQ-014 In IDLE with req != 0, the block SHALL select the first set req bit at or after ptr, searching upward modulo NR_REQ.
REQ-015 On that edge it SHALL register gnt one-hot and sel_key = winner index, set busy, and enter BUSY; grant visible 1 cycle after req sampled.
REQ-016 In IDLE with req == 0, it SHALL hold gnt = 0, busy = 0, sel_key unchanged.
REQ-017 In BUSY, gnt, sel_key and ptr SHALL hold constant; req changes, including the granted bit dropping, SHALL be ignored.
REQ-018 In BUSY with done = 1, on that edge it SHALL clear gnt and busy, set ptr = (winner + 1) mod NR_REQ, and enter IDLE.
REQ-019 A new grant SHALL not occur earlier than the cycle after release, guaranteeing one idle cycle between grants.
REQ-020 done in IDLE SHALL be ignored.
REQ-021 In BUSY, a wait counter SHALL count cycles since grant; it is cleared on entry to BUSY.
REQ-022 If the counter reaches TIMEOUT without done, the block SHALL release exactly as REQ-018 and pulse timeout_err for 1 cycle.
REQ-023 If done and timeout coincide, done SHALL take precedence and timeout_err SHALL stay 0.
REQ-024 ptr wrap: winner NR_REQ-1 SHALL give ptr = 0.
REQ-025 For non-power-of-two NR_REQ, ptr and sel_key SHALL never exceed NR_REQ-1.
REQ-026 gnt SHALL never have more than one bit set.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from req or done to any output.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately force state = IDLE, gnt = 0, sel_key = 0, busy = 0, timeout_err = 0, ptr = 0, counter = 0.
REQ-029 Reset asserted in BUSY SHALL abort the grant with no timeout_err.
REQ-030 After rst_n deassertion, the first arbitration SHALL occur on the first rising edge with req != 0.

Verification (NR_REQ=4, TIMEOUT=8)
REQ-031 Single request: after reset, req=0100 -> next cycle gnt=0100, sel_key=2, busy=1. Done pulse -> next cycle gnt=0000 and ptr=3.
REQ-032 Round-robin rotation: req=1111 held, done pulsed 2 cycles after each grant.
  - Grants SHALL follow the sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
REQ-033 Wrap and skip: ptr=3 with req=0101 -> grant 0001, then ptr=1. Next arbitration with req=0101 -> grant 0100.
REQ-034 Timeout: grant to requester 1 with done never asserted.
  - On the 8th BUSY cycle: timeout_err=1 for one cycle, gnt=0000, ptr=2.
  - Check the done-and-timeout coincidence case: no timeout_err.
REQ-035 Hold and ignore: in BUSY, drop the granted req bit and raise the others -> gnt unchanged until done.
  - A done pulse while IDLE -> no state change.
REQ-036 Reset mid-grant: assert rst_n=0 asynchronously while BUSY -> all outputs 0 without waiting for clk.
  - After deassertion, req=1010 -> grant 0010, since ptr=0.
